ws2812_chain_driver: RTL and testbench
======================================

// Module: ws2812_chain_driver
// PURPOSE
//   Serialises the four 24-bit RGB values produced by the misc MMIO block
//   (led1_rgb..led4_rgb) onto a single-wire WS2812-style smart-LED chain.
//   Sits between the MMIO register block and the board's LED data pin.
//   Snapshots all four values at each frame start so a frame is always coherent.
//   Refreshes continuously while enabled.
// PARAMETERS
//   BIT_CYC      125    clk cycles per data bit (1.25 us at 100 MHz)
//   T0H_CYC      40     high time of a '0' bit, cycles
//   T1H_CYC      80     high time of a '1' bit, cycles
//   RESET_CYC    30000  low (latch) gap after each frame and after reset, cycles
//   COLOR_ORDER  0      0: wire order G,R,B; 1: wire order R,G,B
// PORTS
//   clk          in   1   system clock
//   reset_n      in   1   asynchronous reset, active low
//   enable       in   1   1 = refresh chain continuously
//   led1_rgb     in   24  [0:7]=R [8:15]=G [16:23]=B; first LED on chain
//   led2_rgb     in   24  second LED
//   led3_rgb     in   24  third LED
//   led4_rgb     in   24  fourth (last) LED
//   dout         out  1   registered serial data to LED chain
//   busy         out  1   1 while frame data bits are being sent
//   frame_done   out  1   1-cycle pulse at end of each frame's data bits
// BEHAVIOUR
//   Clock and reset: one clock; reset is asynchronous and active-low.
//   Reset values: dout=0, busy=0, frame_done=0, state=LATCH, counter=0.
//   States:
//     LATCH: dout=0. Counts RESET_CYC cycles. On its last cycle:
//       - if enable=1: load the 96-bit shift register and go to SEND.
//       - otherwise go to IDLE.
//     IDLE: dout=0. When enable=1: load the shift register and go to SEND
//       on the next cycle. The line has already been low >= RESET_CYC cycles.
//     SEND: 96 bits, each exactly BIT_CYC cycles.
//       - dout=1 for cycles 0..TxH_CYC-1 of the bit and 0 for the rest,
//         where TxH_CYC is T0H_CYC or T1H_CYC per the current bit.
//       - The bit counter advances after cycle BIT_CYC-1.
//       - After bit 95, go to LATCH and pulse frame_done for that first
//         LATCH cycle.
//   Shift register load order: led1, led2, led3, led4. Within each LED:
//     - COLOR_ORDER=0: G, R, B.
//     - COLOR_ORDER=1: R, G, B.
//     - Each byte is sent MSB (lowest index) first.
//   Snapshot: inputs are sampled only in the load cycle. Changes during a
//     frame take effect in the next frame.
//   Latency: dout is registered. The first high cycle of bit 0 appears
//     exactly 1 cycle after the load cycle.
//   Continuous enable: frame period is exactly 96*BIT_CYC + RESET_CYC cycles.
//   enable dropped mid-SEND: the current frame completes in full (no
//     truncated frame), then LATCH, then IDLE.
//   enable raised during LATCH: no early exit. The latch gap always
//     completes.
//   busy = (state == SEND). busy is 0 during the frame_done cycle.
//   Counter width: $clog2(max(BIT_CYC, RESET_CYC)+1). Counter wraps only
//     by explicit reload, never by overflow.
//   reset_n asserted mid-frame: dout goes 0 immediately. After release, a
//     full RESET_CYC gap precedes any data.
//   Parameter legality, checked by elaboration-time assertion:
//     1 <= T0H_CYC < T1H_CYC < BIT_CYC and RESET_CYC >= 2.
// TESTING (BIT_CYC=10, T0H_CYC=3, T1H_CYC=7, RESET_CYC=20, COLOR_ORDER=0)
//   1. Release reset with enable=1, led1=24'hFF0000, others 0
//      -> dout low 20 cycles, then one 960-cycle frame.
//      -> Bits 8..15 are 7-high/3-low; all other bits are 3-high/7-low.
//      -> frame_done pulses once.
//   2. enable held 1 -> frame_done pulses spaced exactly 980 cycles apart.
//      busy is high 960 of every 980 cycles.
//   3. Change led2 from 0 to 24'h00FF00 mid-frame -> the current frame still
//      sends 0 for led2. The next frame sends bits 24..31 as '1'.
//   4. Drop enable at bit 40 -> the frame completes all 96 bits, 20 low
//      cycles follow, then dout stays 0 and busy stays 0 until enable
//      rises again.
//   5. Assert reset_n=0 at bit 50 -> dout=0 in the same cycle. After
//      release: 20 low cycles, then a fresh frame from bit 0.
//   6. COLOR_ORDER=1, led4=24'h123456 -> the last 24 bits on the wire
//      decode as 12,34,56.

Source files
------------

// File: rtl/ws2812_chain_driver.sv
// WS2812 chain driver: serialises four 24-bit RGB values onto one wire.
// Ports: clk, reset_n, enable, led1..4_rgb in; dout, busy, frame_done out.
module ws2812_chain_driver #(
  parameter int BIT_CYC     = 125,
  parameter int T0H_CYC     = 40,
  parameter int T1H_CYC     = 80,
  parameter int RESET_CYC   = 30000,
  parameter int COLOR_ORDER = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [0:23] led1_rgb,
  input  logic [0:23] led2_rgb,
  input  logic [0:23] led3_rgb,
  input  logic [0:23] led4_rgb,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int CNT_MAX =
    (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYC - 1);
  localparam logic [CW-1:0] T0H      = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H      = CW'(T1H_CYC);
  localparam logic [6:0]    LAST_BIT = 7'd95;

  if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC &&
        T1H_CYC < BIT_CYC && RESET_CYC >= 2)) begin : g_bad_params
    $error("ws2812_chain_driver: illegal timing parameters");
  end

  typedef enum logic [1:0] {
    LATCH = 2'd0,
    IDLE  = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0]    bit_idx, bit_n;
  logic [95:0]   shreg, shreg_n;
  logic [95:0]   frame;
  logic          done_n;
  logic          dout_n;

  // Index 0 of each colour byte is its MSB, so ascending slices
  // land MSB-first in the descending shift register.
  function automatic logic [23:0] wire_order(input logic [0:23] v);
    logic [23:0] grb;
    logic [23:0] rgb;
    grb = {v[8:15], v[0:7], v[16:23]};
    rgb = v;
    return (COLOR_ORDER == 1) ? rgb : grb;
  endfunction

  assign frame = {wire_order(led1_rgb), wire_order(led2_rgb),
                  wire_order(led3_rgb), wire_order(led4_rgb)};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    done_n  = 1'b0;
    unique case (state)
      LATCH: begin
        if (cnt == RST_LAST) begin
          cnt_n = '0;
          bit_n = '0;
          if (enable) begin
            state_n = SEND;
            shreg_n = frame;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (enable) begin
          state_n = SEND;
          shreg_n = frame;
          cnt_n   = '0;
          bit_n   = '0;
        end
      end
      SEND: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {shreg[94:0], 1'b0};
          if (bit_idx == LAST_BIT) begin
            state_n = LATCH;
            done_n  = 1'b1;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = LATCH;
        cnt_n   = '0;
      end
    endcase
    // dout is derived from the next state so the registered
    // output lines up with the cycle the counter describes.
    dout_n = (state_n == SEND) &&
             (cnt_n < (shreg_n[95] ? T1H : T0H));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LATCH;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= shreg_n;
      dout       <= dout_n;
      frame_done <= done_n;
    end
  end

  assign busy = (state == SEND);

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Bench for ws2812_chain_driver: GRB and RGB instances on shared inputs,
// waveform checked bit-by-bit against a byte-level frame model.
module tb_ws2812_chain_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [23:0] l1, l2, l3, l4;
  logic        dout0, busy0, fd0;
  logic        dout1, busy1, fd1;
  logic [95:0] g0, g1;
  int          tests;
  int          fails;

  always #5 clk = ~clk;

  ws2812_chain_driver #(
    .BIT_CYC(10), .T0H_CYC(3), .T1H_CYC(7),
    .RESET_CYC(20), .COLOR_ORDER(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .led1_rgb(l1), .led2_rgb(l2), .led3_rgb(l3), .led4_rgb(l4),
    .dout(dout0), .busy(busy0), .frame_done(fd0)
  );

  ws2812_chain_driver #(
    .BIT_CYC(10), .T0H_CYC(3), .T1H_CYC(7),
    .RESET_CYC(20), .COLOR_ORDER(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .led1_rgb(l1), .led2_rgb(l2), .led3_rgb(l3), .led4_rgb(l4),
    .dout(dout1), .busy(busy1), .frame_done(fd1)
  );

  task automatic chk(input string tag,
                     input logic [95:0] got,
                     input logic [95:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wire bits of a frame, first-sent bit at [95].
  function automatic logic [95:0] wire_bits(input int ord,
      input logic [23:0] a, input logic [23:0] b,
      input logic [23:0] c, input logic [23:0] d);
    logic [95:0] w;
    logic [23:0] v;
    logic [7:0]  r, g, bl;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      v  = (i == 0) ? a : (i == 1) ? b : (i == 2) ? c : d;
      r  = v[23:16];
      g  = v[15:8];
      bl = v[7:0];
      w  = {w[71:0], (ord == 1) ? {r, g, bl} : {g, r, bl}};
    end
    return w;
  endfunction

  function automatic logic [9:0] pattern(input logic bv);
    logic [9:0] p;
    for (int c = 0; c < 10; c++)
      p[c] = (c < (bv ? 7 : 3));
    return p;
  endfunction

  task automatic randomize_leds();
    l1 = 24'($urandom);
    l2 = 24'($urandom);
    l3 = 24'($urandom);
    l4 = 24'($urandom);
  endtask

  task automatic check_gap(input string tag, input int n,
                           input bit fd_first, input int raise_at);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (dout0 !== 1'b0 || dout1 !== 1'b0 ||
          busy0 !== 1'b0 || busy1 !== 1'b0)
        bad++;
      if (i == 0)
        chk({tag, " fd"}, {fd0, fd1}, fd_first ? 2'b11 : 2'b00);
      else if (fd0 !== 1'b0 || fd1 !== 1'b0)
        bad++;
      if (i == raise_at)
        enable = 1'b1;
      @(negedge clk);
    end
    chk({tag, " low"}, bad, 0);
  endtask

  // act: 1 new random leds, 2 drop enable, 3 reset, 4 led2=00FF00
  task automatic check_frame(input string tag, input int act_bit,
                             input int act,
                             output logic [95:0] got0,
                             output logic [95:0] got1);
    logic [95:0] e0, e1;
    logic [9:0]  s0, s1;
    int          bad;
    e0   = wire_bits(0, l1, l2, l3, l4);
    e1   = wire_bits(1, l1, l2, l3, l4);
    got0 = '0;
    got1 = '0;
    bad  = 0;
    for (int b = 0; b < 96; b++) begin
      for (int c = 0; c < 10; c++) begin
        s0[c] = dout0;
        s1[c] = dout1;
        if (busy0 !== 1'b1 || busy1 !== 1'b1 ||
            fd0 !== 1'b0 || fd1 !== 1'b0)
          bad++;
        if (c == 0 && b == act_bit) begin
          case (act)
            1: randomize_leds();
            2: enable = 1'b0;
            4: l2 = 24'h00FF00;
            3: begin
              reset_n = 1'b0;
              #1;
              chk({tag, " rst"}, {dout0, dout1, busy0, busy1}, 4'b0);
              return;
            end
            default: ;
          endcase
        end
        @(negedge clk);
      end
      chk($sformatf("%s g b%0d", tag, b), s0, pattern(e0[95-b]));
      chk($sformatf("%s r b%0d", tag, b), s1, pattern(e1[95-b]));
      got0 = {got0[94:0], s0[3]};
      got1 = {got1[94:0], s1[3]};
    end
    chk({tag, " busy"}, bad, 0);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    enable  = 1'b1;
    l1 = 24'hFF0000;
    l2 = 24'h0;
    l3 = 24'h0;
    l4 = 24'h0;
    repeat (3) @(negedge clk);
    chk("reset", {dout0, busy0, fd0, dout1, busy1, fd1}, 6'b0);
    reset_n = 1'b1;

    check_gap("t1 gap", 20, 1'b0, -1);
    check_frame("t1", -1, 0, g0, g1);
    chk("t1 bits", g0, {8'h00, 8'hFF, 80'h0});

    check_gap("t2 gap", 20, 1'b1, -1);
    check_frame("t3 old", 30, 4, g0, g1);
    chk("t3 old led2", g0[71:64], 8'h00);
    check_gap("t3 gap", 20, 1'b1, -1);
    check_frame("t3 new", -1, 0, g0, g1);
    chk("t3 new led2", g0[71:64], 8'hFF);

    for (int k = 0; k < 3; k++) begin
      randomize_leds();
      check_gap($sformatf("rnd%0d gap", k), 20, 1'b1, -1);
      check_frame($sformatf("rnd%0d", k),
                  int'($urandom_range(1, 94)), 1, g0, g1);
    end

    l4 = 24'h123456;
    check_gap("t6 gap", 20, 1'b1, -1);
    check_frame("t6", -1, 0, g0, g1);
    chk("t6 led4 rgb", g1[23:0], 24'h123456);

    check_gap("t4 gap", 20, 1'b1, -1);
    check_frame("t4", 40, 2, g0, g1);
    check_gap("t4 idle", 70, 1'b1, -1);
    randomize_leds();
    enable = 1'b1;
    check_gap("t4 rise", 1, 1'b0, -1);
    check_frame("t4 resume", -1, 0, g0, g1);

    check_gap("lr gap", 20, 1'b1, -1);
    check_frame("lr", 60, 2, g0, g1);
    randomize_leds();
    check_gap("lr raise", 20, 1'b1, 5);
    check_frame("lr next", -1, 0, g0, g1);

    check_gap("t5 gap", 20, 1'b1, -1);
    check_frame("t5", 50, 3, g0, g1);
    repeat (2) @(negedge clk);
    chk("t5 held", {dout0, busy0, fd0, dout1, busy1, fd1}, 6'b0);
    randomize_leds();
    reset_n = 1'b1;
    check_gap("t5 gap2", 20, 1'b0, -1);
    check_frame("t5 fresh", -1, 0, g0, g1);
    chk("t5 end fd", {fd0, fd1, busy0, busy1}, 4'b1100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
